// File: rtl/adc_sum_sq_pkg.sv
// Shared types and field positions for the ADC sum-of-squares window scheduler.
package adc_sum_sq_pkg;

  localparam int unsigned N_CH_DEF   = 4;
  localparam int unsigned SAMP_W_DEF = 8;
  localparam int unsigned ACC_W_DEF  = 32;
  localparam int unsigned LEN_W_DEF  = 16;

  localparam int unsigned STATUS_CNT_LSB   = 16;
  localparam int unsigned STATUS_CNT_W     = 16;
  localparam int unsigned STATUS_OVF_LSB   = 12;
  localparam int unsigned STATUS_OVF_W     = 4;
  localparam int unsigned STATUS_STATE_LSB = 0;
  localparam int unsigned STATUS_STATE_W   = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SYNC = 2'd1,
    INTEG     = 2'd2
  } state_e;

endpackage

// File: rtl/sat_sq_acc.sv
// One channel: signed square and saturating accumulate with sticky overflow.
// sum_nxt/ovf_nxt expose the post-sample result so the final sample can be dumped directly.
module sat_sq_acc #(
  parameter int unsigned SAMP_W = 8,
  parameter int unsigned ACC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [SAMP_W-1:0] sample,
  output logic        [ACC_W-1:0]  sum_nxt,
  output logic                     ovf_nxt
);

  logic        [ACC_W-1:0]    acc_q, acc_d;
  logic                       ovf_q, ovf_d;
  logic signed [2*SAMP_W-1:0] samp_ext;
  logic signed [2*SAMP_W-1:0] prod;
  logic        [2*SAMP_W-1:0] sq;
  logic        [ACC_W:0]      sum_wide;

  always_comb begin
    samp_ext = (2*SAMP_W)'(sample);
    prod     = samp_ext * samp_ext;
    sq       = unsigned'(prod);
    // One extra bit catches the carry out that marks saturation.
    sum_wide = {1'b0, acc_q} + {{(ACC_W+1-2*SAMP_W){1'b0}}, sq};
    sum_nxt  = sum_wide[ACC_W] ? '1 : sum_wide[ACC_W-1:0];
    ovf_nxt  = ovf_q | sum_wide[ACC_W];

    acc_d = acc_q;
    ovf_d = ovf_q;
    if (clr) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (en) begin
      acc_d = sum_nxt;
      ovf_d = ovf_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: rtl/adc_sum_sq_sched.sv
// Integration-window scheduler: arm/sync/count FSM driving N_CH sum-of-squares
// accumulators and the readback dump registers.
module adc_sum_sq_sched
  import adc_sum_sq_pkg::*;
#(
  parameter int unsigned N_CH   = N_CH_DEF,
  parameter int unsigned SAMP_W = SAMP_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned LEN_W  = LEN_W_DEF
) (
  input  logic                     user_clk,
  input  logic                     user_rst_n,
  input  logic                     arm,
  input  logic                     continuous,
  input  logic                     abort,
  input  logic [LEN_W-1:0]         integ_len,
  input  logic                     sync_in,
  input  logic                     adc_valid,
  input  logic [N_CH*SAMP_W-1:0]   adc_data,
  output logic [N_CH*ACC_W-1:0]    sum_sq_out,
  output logic [31:0]              status,
  output logic                     busy,
  output logic                     done
);

  state_e                    state_q, state_d;
  logic                      arm_q;
  logic                      arm_rise;
  logic [LEN_W:0]            cnt_q, cnt_d, cnt_load;
  logic [N_CH*ACC_W-1:0]     sum_sq_q, sum_sq_d;
  logic [N_CH*ACC_W-1:0]     sum_nxt_all;
  logic [N_CH-1:0]           ovf_nxt_all;
  logic [STATUS_OVF_W-1:0]   ovf_last_q, ovf_last_d;
  logic [STATUS_CNT_W-1:0]   win_cnt_q, win_cnt_d;
  logic                      done_q, done_d;
  logic                      acc_clr, acc_en, last;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    sat_sq_acc #(
      .SAMP_W(SAMP_W),
      .ACC_W (ACC_W)
    ) u_acc (
      .clk    (user_clk),
      .rst_n  (user_rst_n),
      .clr    (acc_clr),
      .en     (acc_en),
      .sample (adc_data[k*SAMP_W +: SAMP_W]),
      .sum_nxt(sum_nxt_all[k*ACC_W +: ACC_W]),
      .ovf_nxt(ovf_nxt_all[k])
    );
  end

  always_comb begin
    arm_rise = arm & ~arm_q;
    cnt_load = {1'b0, integ_len};
    if (integ_len == '0) cnt_load = {1'b1, {LEN_W{1'b0}}};
    last = (state_q == INTEG) && adc_valid && (cnt_q == (LEN_W+1)'(1));

    state_d    = state_q;
    cnt_d      = cnt_q;
    sum_sq_d   = sum_sq_q;
    ovf_last_d = ovf_last_q;
    win_cnt_d  = win_cnt_q;
    done_d     = 1'b0;
    acc_clr    = 1'b0;
    acc_en     = 1'b0;

    if (abort) begin
      state_d = IDLE;
      acc_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE: if (arm_rise) state_d = WAIT_SYNC;
        WAIT_SYNC: if (sync_in) begin
          state_d = INTEG;
          cnt_d   = cnt_load;
          acc_clr = 1'b1;
        end
        INTEG: if (adc_valid) begin
          if (last) begin
            // Dump the sum that includes this sample while the accumulators clear.
            sum_sq_d   = sum_nxt_all;
            ovf_last_d = '0;
            for (int unsigned k = 0; k < STATUS_OVF_W; k++)
              if (k < N_CH) ovf_last_d[k] = ovf_nxt_all[k];
            win_cnt_d = win_cnt_q + 1'b1;
            done_d    = 1'b1;
            acc_clr   = 1'b1;
            if (continuous) cnt_d = cnt_load;
            else            state_d = IDLE;
          end else begin
            acc_en = 1'b1;
            cnt_d  = cnt_q - 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_q    <= IDLE;
      arm_q      <= 1'b0;
      cnt_q      <= '0;
      sum_sq_q   <= '0;
      ovf_last_q <= '0;
      win_cnt_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      arm_q      <= arm;
      cnt_q      <= cnt_d;
      sum_sq_q   <= sum_sq_d;
      ovf_last_q <= ovf_last_d;
      win_cnt_q  <= win_cnt_d;
      done_q     <= done_d;
    end
  end

  assign sum_sq_out = sum_sq_q;
  assign done       = done_q;
  assign busy       = (state_q == WAIT_SYNC) || (state_q == INTEG);
  assign status     = {win_cnt_q, ovf_last_q,
                       {(STATUS_OVF_LSB-STATUS_STATE_W){1'b0}}, state_q};

endmodule

// File: tb/tb_adc_sum_sq_sched.sv
// Directed bench for adc_sum_sq_sched: default, ACC_W=16 and LEN_W=4 builds share stimulus.
module tb_adc_sum_sq_sched;

  logic         clk, rst_n, arm, cont, abort, sync, valid;
  logic [15:0]  len;
  logic [31:0]  data;

  logic [127:0] sum_a;  logic [31:0] status_a; logic busy_a, done_a;
  logic [63:0]  sum_b;  logic [31:0] status_b; logic busy_b, done_b;
  logic [127:0] sum_c;  logic [31:0] status_c; logic busy_c, done_c;

  int checks = 0;
  int errors = 0;

  adc_sum_sq_sched dut (
    .user_clk(clk), .user_rst_n(rst_n), .arm(arm), .continuous(cont), .abort(abort),
    .integ_len(len), .sync_in(sync), .adc_valid(valid), .adc_data(data),
    .sum_sq_out(sum_a), .status(status_a), .busy(busy_a), .done(done_a));

  adc_sum_sq_sched #(.ACC_W(16)) dut16 (
    .user_clk(clk), .user_rst_n(rst_n), .arm(arm), .continuous(cont), .abort(abort),
    .integ_len(len), .sync_in(sync), .adc_valid(valid), .adc_data(data),
    .sum_sq_out(sum_b), .status(status_b), .busy(busy_b), .done(done_b));

  adc_sum_sq_sched #(.LEN_W(4)) dut_l4 (
    .user_clk(clk), .user_rst_n(rst_n), .arm(arm), .continuous(cont), .abort(abort),
    .integ_len(len[3:0]), .sync_in(sync), .adc_valid(valid), .adc_data(data),
    .sum_sq_out(sum_c), .status(status_c), .busy(busy_c), .done(done_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         arm, sync, valid;
    logic [15:0]  len;
    logic [31:0]  data;
    logic         exp_done;
    logic [1:0]   exp_state;
    logic [127:0] exp_sum;
    logic [15:0]  exp_cnt;
  } vec_t;

  function automatic vec_t mk(input logic a, input logic s, input logic v,
                              input logic [15:0] l, input logic [31:0] d,
                              input logic ed, input logic [1:0] es,
                              input logic [127:0] esum, input logic [15:0] ec);
    vec_t r;
    r.arm = a; r.sync = s; r.valid = v; r.len = l; r.data = d;
    r.exp_done = ed; r.exp_state = es; r.exp_sum = esum; r.exp_cnt = ec;
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[15];
  logic [127:0] s36, s32514, s8, s20000, s16;
  logic [63:0]  sffff, s8b;
  logic [15:0]  exp_cnt;

  initial begin
    s36    = {4{32'd36}};
    s32514 = {96'd0, 32'd32514};
    s8     = {4{32'd8}};
    s20000 = {4{32'h20000}};
    s16    = {4{32'd16}};
    sffff  = {4{16'hFFFF}};
    s8b    = {4{16'd8}};

    tbl[0]  = mk(1, 0, 0, 4, 32'h0,        0, 1, 128'd0, 0);
    tbl[1]  = mk(1, 1, 1, 4, 32'h03030303, 0, 2, 128'd0, 0);
    tbl[2]  = mk(1, 0, 1, 4, 32'h03030303, 0, 2, 128'd0, 0);
    tbl[3]  = mk(1, 0, 1, 4, 32'h03030303, 0, 2, 128'd0, 0);
    tbl[4]  = mk(1, 0, 1, 4, 32'h03030303, 0, 2, 128'd0, 0);
    tbl[5]  = mk(1, 0, 1, 4, 32'h03030303, 1, 0, s36,    1);
    tbl[6]  = mk(0, 0, 0, 4, 32'h0,        0, 0, s36,    1);
    tbl[7]  = mk(1, 0, 0, 3, 32'h0,        0, 1, s36,    1);
    tbl[8]  = mk(1, 1, 1, 3, 32'h00000080, 0, 2, s36,    1);
    tbl[9]  = mk(1, 0, 1, 3, 32'h00000080, 0, 2, s36,    1);
    tbl[10] = mk(1, 0, 0, 3, 32'h00000080, 0, 2, s36,    1);
    tbl[11] = mk(1, 0, 1, 3, 32'h0000007F, 0, 2, s36,    1);
    tbl[12] = mk(1, 0, 0, 3, 32'h0000007F, 0, 2, s36,    1);
    tbl[13] = mk(1, 0, 1, 3, 32'h000000FF, 1, 0, s32514, 2);
    tbl[14] = mk(0, 0, 0, 3, 32'h0,        0, 0, s32514, 2);

    rst_n = 1'b0; arm = 0; cont = 0; abort = 0; sync = 0; valid = 0; len = '0; data = '0;
    #12;
    chk("reset sum",    sum_a, 128'd0);
    chk("reset status", status_a, 32'd0);
    chk("reset busy",   busy_a, 1'b0);
    chk("reset done",   done_a, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      arm = tbl[i].arm; sync = tbl[i].sync; valid = tbl[i].valid;
      len = tbl[i].len; data = tbl[i].data;
      step();
      chk($sformatf("vec%0d done", i),  done_a, tbl[i].exp_done);
      chk($sformatf("vec%0d state", i), status_a[1:0], tbl[i].exp_state);
      chk($sformatf("vec%0d busy", i),  busy_a, tbl[i].exp_state != 2'd0);
      chk($sformatf("vec%0d sum", i),   sum_a, tbl[i].exp_sum);
      chk($sformatf("vec%0d count", i), status_a[31:16], tbl[i].exp_cnt);
    end

    // Continuous windows of length 2, sync pulse mid-window ignored.
    arm = 1; step();
    chk("cont arm state", status_a[1:0], 2'd1);
    cont = 1; len = 2; data = 32'h02020202; valid = 1; sync = 1; step();
    chk("cont sync state", status_a[1:0], 2'd2);
    sync = 0;
    exp_cnt = 2;
    for (int i = 1; i <= 6; i++) begin
      sync = (i == 3); valid = 1; step();
      chk($sformatf("cont%0d done", i), done_a, (i % 2) == 0);
      chk($sformatf("cont%0d state", i), status_a[1:0], 2'd2);
      if ((i % 2) == 0) begin
        exp_cnt++;
        chk($sformatf("cont%0d sum", i), sum_a, s8);
        chk($sformatf("cont%0d count", i), status_a[31:16], exp_cnt);
      end
    end
    sync = 0; valid = 0; step();
    chk("cont gap done", done_a, 1'b0);
    cont = 0; valid = 1; step();
    chk("cont tail1 done", done_a, 1'b0);
    step();
    chk("cont tail2 done",  done_a, 1'b1);
    chk("cont tail2 state", status_a[1:0], 2'd0);
    chk("cont tail2 count", status_a[31:16], 16'd6);

    // Saturation in the ACC_W=16 build, then ovf clears on a clean window.
    arm = 0; valid = 0; step();
    arm = 1; step();
    chk("ovf arm state", status_a[1:0], 2'd1);
    sync = 1; len = 8; data = 32'h80808080; valid = 1; step();
    sync = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk($sformatf("ovf%0d done", i), done_a, i == 8);
    end
    chk("ovf16 sum",    sum_b, sffff);
    chk("ovf16 flags",  status_b[15:12], 4'hF);
    chk("ovf16 count",  status_b[31:16], 16'd7);
    chk("ovf32 sum",    sum_a, s20000);
    chk("ovf32 flags",  status_a[15:12], 4'h0);
    arm = 0; valid = 0; step();
    arm = 1; step();
    sync = 1; data = 32'h01010101; valid = 1; step();
    sync = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk($sformatf("clean%0d done16", i), done_b, i == 8);
    end
    chk("clean16 sum",   sum_b, s8b);
    chk("clean16 flags", status_b[15:12], 4'h0);
    chk("clean16 count", status_b[31:16], 16'd8);
    chk("clean16 busy",  busy_b, 1'b0);

    // Abort on the last sample wins; arm held high does not re-arm.
    arm = 0; valid = 0; step();
    arm = 1; step();
    sync = 1; len = 2; data = 32'h05050505; valid = 1; step();
    sync = 0; step();
    abort = 1; step();
    chk("abort done",   done_a, 1'b0);
    chk("abort state",  status_a[1:0], 2'd0);
    chk("abort busy",   busy_a, 1'b0);
    chk("abort sum",    sum_a, s8);
    chk("abort count",  status_a[31:16], 16'd8);
    chk("abort flags16", status_b[15:12], 4'h0);
    abort = 0; valid = 0; sync = 1; step();
    chk("held arm state", status_a[1:0], 2'd0);
    sync = 0; arm = 0; step();
    arm = 1; step();
    chk("rearm state", status_a[1:0], 2'd1);

    // integ_len=0 spans 2^LEN_W samples in the LEN_W=4 build.
    sync = 1; len = 0; data = 32'h01010101; valid = 1; step();
    sync = 0;
    chk("len0 state", status_c[1:0], 2'd2);
    for (int i = 1; i <= 16; i++) begin
      step();
      chk($sformatf("len0_%0d done", i), done_c, i == 16);
    end
    chk("len0 sum",    sum_c, s16);
    chk("len0 state",  status_c[1:0], 2'd0);
    chk("len0 busy",   busy_c, 1'b0);
    chk("len0 count",  status_c[31:16], 16'd9);
    chk("long still integ", status_a[1:0], 2'd2);
    chk("long busy",   busy_a, 1'b1);

    // Asynchronous reset mid-window.
    #2 rst_n = 1'b0;
    #1;
    chk("arst sum",    sum_a, 128'd0);
    chk("arst status", status_a, 32'd0);
    chk("arst busy",   busy_a, 1'b0);
    chk("arst done",   done_a, 1'b0);
    chk("arst sum l4", sum_c, 128'd0);
    #3 rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
